// File: rtl/sdram_audio_fetch.sv
// Audio sample fetcher: streams 16-bit words from one SDRAM half into a sample FIFO, ping-ponging halves.
// Latency: read issued one cycle after IDLE sees room; sample_out/sample_valid registered one cycle after sample_req.
// Backpressure: reads issue only while the FIFO has room; an empty-FIFO pop returns zero and pulses underrun.
// Optional: define AUDIO_FETCH_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module sdram_audio_fetch #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] HALF_LAST  = 24'hFFFFFF,
  parameter logic        START_HALF = 1'b0
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        enable,
  output logic [25:0] addr_out,
  output logic        read_out,
  input  logic        ack_in,
  input  logic [15:0] readdata_in,
  input  logic        sample_req,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        underrun,
  output logic        cur_half,
  output logic        half_done
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [23:0]        offset;
  logic               half;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [15:0]        mem [FIFO_DEPTH];
  logic               room;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign room       = (count < DEPTH_C);
  assign fifo_empty = (count == '0);
  // Acks are only meaningful while a read is actually outstanding.
  assign push       = (state == REQ) && ack_in;
  // An empty-FIFO pop is an underrun; it never moves the read pointer.
  assign pop        = sample_req && !fifo_empty;

  assign addr_out  = {1'b0, half, offset};
  assign cur_half  = half;
  assign half_done = push && (offset == HALF_LAST);

  // State register; reset drops read_out immediately since read_out decodes REQ.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and read strobe; GAP forces one low cycle so the arbiter can slot in writes.
  always_comb begin
    state_nxt = state;
    read_out  = 1'b0;
    case (state)
      IDLE: if (enable && room) state_nxt = REQ;
      REQ: begin
        read_out = 1'b1;
        if (ack_in) state_nxt = GAP;
      end
      GAP: state_nxt = (enable && room) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word address walks the current half, then wraps and flips to the other half.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      offset <= '0;
      half   <= START_HALF;
    end else if (push) begin
      if (offset == HALF_LAST) begin
        offset <= '0;
        half   <= ~half;
      end else begin
        offset <= offset + 24'd1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample storage; contents need no reset because count gates every read.
  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= readdata_in;
  end

  // Registered sample port: head word on a good pop, zero plus underrun on an empty pop.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      underrun     <= sample_req && fifo_empty;
      if (sample_req) sample_out <= fifo_empty ? 16'h0000 : mem[rd_ptr];
    end
  end

`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
  // Saturating underrun tally, advanced alongside the underrun pulse.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      underrun_cnt <= '0;
    else if (sample_req && fifo_empty && (underrun_cnt != 16'hFFFF))
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
